// File: rtl/seq_match_pkg.sv
// Shared state type, reset-default configuration and length clamp for the seq_match run controller.
package seq_match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Out of reset the block is the classic non-overlapping "1000" Moore detector.
  localparam logic [3:0]  DEF_PATTERN = 4'b1000;
  localparam int unsigned DEF_LEN     = 4;
  localparam logic        DEF_OVERLAP = 1'b0;
  localparam int unsigned DEF_LIMIT   = 0;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_match_hist.sv
// Bit history, fill counter and masked pattern compare; hit is combinational on the bit being shifted in.
// No backpressure: a bit is consumed on every cycle shift_en is high.
module seq_match_hist
  import seq_match_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             din,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             hit
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d, hist_nxt, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fill_nxt;

  always_comb begin
    hist_nxt = {hist_q[PAT_W-2:0], din};
    fill_nxt = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);

    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end

    // Evaluated against the post-shift view so detect can be registered on the same edge.
    hit = shift_en && (fill_nxt >= len) && ((hist_nxt & mask) == (pattern & mask));

    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      hist_d = hist_nxt;
      fill_d = (hit && !overlap) ? '0 : fill_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern detection run controller; SEQ_MATCH_CTRL_TIMEOUT_EN adds a no-match timeout.
// detect/match_cnt update on the edge sampling the completing bit; config handshake accepted only outside RUN.
module seq_match_ctrl
  import seq_match_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
  ,
  parameter int TO_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_limit,
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             timeout,
`endif
  input  logic             start,
  input  logic             abort,
  input  logic             din_valid,
  input  logic             din,
  output logic             detect,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_PATTERN);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(clamp_len(DEF_LEN, PAT_W));
  localparam logic [CNT_W-1:0] RST_LIM = CNT_W'(DEF_LIMIT);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             detect_q, detect_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;
  logic             cfg_fire, shift_en, hist_clr, hit;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
  logic [TO_W-1:0]  to_lim_q, to_lim_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d, to_inc;
  logic             timeout_q, timeout_d;
`endif

  seq_match_hist #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (hist_clr),
    .shift_en (shift_en),
    .din      (din),
    .overlap  (ovl_q),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_comb begin
    cfg_fire = cfg_valid && rdy_q;
    shift_en = (state_q == ST_RUN) && din_valid;
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    lim_d    = lim_q;
    cnt_d    = cnt_q;
    detect_d = 1'b0;
    hist_clr = 1'b0;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
    to_lim_d  = to_lim_q;
    to_cnt_d  = to_cnt_q;
    to_inc    = to_cnt_q + TO_W'(1);
    timeout_d = timeout_q;
`endif

    if (cfg_fire) begin
      pat_d = cfg_pattern;
      len_d = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
      ovl_d = cfg_overlap;
      lim_d = cfg_limit;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
      to_lim_d  = cfg_timeout;
      timeout_d = 1'b0;
`endif
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          cnt_d    = '0;
          hist_clr = 1'b1;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
          to_cnt_d  = '0;
          timeout_d = 1'b0;
`endif
        end else if (cfg_fire) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // abort wins over a match completing in the same cycle.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          detect_d = 1'b1;
          cnt_d    = cnt_inc;
          if ((lim_q != '0) && (cnt_inc == lim_q)) state_d = ST_DONE;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
        else if (shift_en) begin
          to_cnt_d = to_inc;
          if ((to_lim_q != '0) && (to_inc == to_lim_q)) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    rdy_d  = (state_d != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pat_q    <= RST_PAT;
      len_q    <= RST_LEN;
      ovl_q    <= DEF_OVERLAP;
      lim_q    <= RST_LIM;
      cnt_q    <= '0;
      detect_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b1;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
      to_lim_q  <= '0;
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      lim_q    <= lim_d;
      cnt_q    <= cnt_d;
      detect_q <= detect_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
      to_lim_q  <= to_lim_d;
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign cfg_ready = rdy_q;
  assign detect    = detect_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
  assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Bench for seq_match_ctrl: directed scenarios plus randomized runs against a bit-queue reference model.
module tb_seq_match_ctrl;
  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int LEN_W = 3;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic [CNT_W-1:0] cfg_limit = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             din_valid = 1'b0;
  logic             din = 1'b0;
  logic             detect, busy, done;
  logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
  logic [7:0]       cfg_timeout = '0;
  logic             timeout;
  int               m_to_lim, m_to_cnt;
  bit               m_to;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int det_seen = 0;
  int d0;

  // Reference model: matching is "the newest len bits seen since the last reset point equal the pattern".
  int               m_state, m_cnt, m_len, m_lim;
  bit               m_det, m_ovl;
  bit [PAT_W-1:0]   m_pat;
  bit               m_seg[$];

  seq_match_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_limit   (cfg_limit),
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
    .cfg_timeout (cfg_timeout),
    .timeout     (timeout),
`endif
    .start       (start),
    .abort       (abort),
    .din_valid   (din_valid),
    .din         (din),
    .detect      (detect),
    .busy        (busy),
    .done        (done),
    .match_cnt   (match_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit seg_match();
    if (m_seg.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (m_seg[m_seg.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    bit fire;
    fire = cfg_valid && (m_state != M_RUN);
    m_det = 1'b0;
    if (m_state == M_RUN) begin
      if (abort) m_state = M_IDLE;
      else if (din_valid) begin
        m_seg.push_back(din);
        if (m_seg.size() > PAT_W) void'(m_seg.pop_front());
        if (seg_match()) begin
          m_det = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
          if (!m_ovl) m_seg.delete();
          if (m_lim != 0 && m_cnt == m_lim) m_state = M_DONE;
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
          m_to_cnt = 0;
        end else begin
          m_to_cnt++;
          if (m_to_lim != 0 && m_to_cnt == m_to_lim) begin
            m_state = M_DONE;
            m_to = 1'b1;
          end
`endif
        end
      end
    end else if (start) begin
      m_state = M_RUN;
      m_cnt = 0;
      m_seg.delete();
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
      m_to_cnt = 0;
      m_to = 1'b0;
`endif
    end else if (fire) begin
      m_state = M_IDLE;
    end
    if (fire) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > PAT_W) ? PAT_W : int'(cfg_len));
      m_ovl = cfg_overlap;
      m_lim = int'(cfg_limit);
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
      m_to_lim = int'(cfg_timeout);
      m_to = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    if (detect === 1'b1) det_seen++;
    chk("detect", detect, m_det);
    chk("busy", busy, m_state == M_RUN);
    chk("done", done, m_state == M_DONE);
    chk("cfg_ready", cfg_ready, m_state != M_RUN);
    chk("match_cnt", match_cnt, m_cnt);
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
    chk("timeout", timeout, m_to);
`endif
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_detect", detect, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    m_state = M_IDLE; m_cnt = 0; m_det = 1'b0;
    m_pat = 4'b1000; m_len = 4; m_ovl = 1'b0; m_lim = 0;
    m_seg.delete();
`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
    m_to_lim = 0; m_to_cnt = 0; m_to = 1'b0;
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic v, input logic b);
    din_valid = v; din = b;
    tick();
    din_valid = 1'b0; din = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(1'b1, bits[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o, input logic [CNT_W-1:0] lim);
    cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_limit = lim;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    do_reset();

    // Defaults behave as a non-overlapping "1000" detector.
    d0 = det_seen;
    pulse_start();
    send_bits(32'b1000110000, 10);
    chk("t1_detects", det_seen - d0, 2);
    chk("t1_cnt", match_cnt, 2);
    chk("t1_busy", busy, 1);

    // Overlap versus non-overlap on 101010.
    pulse_abort();
    cfg(4'b1010, 3'd4, 1'b0, 8'd0);
    pulse_start();
    send_bits(32'b101010, 6);
    chk("t2_nonovl_cnt", match_cnt, 1);
    pulse_abort();
    cfg(4'b1010, 3'd4, 1'b1, 8'd0);
    pulse_start();
    d0 = det_seen;
    send_bits(32'b101010, 6);
    chk("t2_ovl_cnt", match_cnt, 2);
    chk("t2_ovl_detects", det_seen - d0, 2);

    // Stop on limit.
    pulse_abort();
    cfg(4'b1000, 3'd4, 1'b0, 8'd2);
    pulse_start();
    d0 = det_seen;
    send_bits(32'b100010001000, 12);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_cnt", match_cnt, 2);
    chk("t3_cfg_ready", cfg_ready, 1);
    chk("t3_detects", det_seen - d0, 2);

    // Gaps in din_valid mid-pattern, then abort on a completing bit.
    cfg(4'b1000, 3'd4, 1'b0, 8'd0);
    chk("t4_idle_after_cfg", done, 0);
    pulse_start();
    d0 = det_seen;
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b0);
    send(1'b1, 1'b0); send(1'b0, 1'b1); send(1'b0, 1'b0); send(1'b1, 1'b0);
    chk("t4_gap_detects", det_seen - d0, 1);
    send_bits(32'b100, 3);
    d0 = det_seen;
    abort = 1'b1; din_valid = 1'b1; din = 1'b0;
    tick();
    abort = 1'b0; din_valid = 1'b0;
    chk("t4_abort_detect", detect, 0);
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_cfg_ready", cfg_ready, 1);
    chk("t4_abort_cnt", match_cnt, 1);
    tick();
    chk("t4_abort_no_late_detect", det_seen - d0, 0);

    // Length clamps, with config and start in the same cycle.
    cfg_valid = 1'b1; cfg_pattern = 4'b0001; cfg_len = 3'd0; cfg_overlap = 1'b0; cfg_limit = 8'd0;
    start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    d0 = det_seen;
    send_bits(32'b1101, 4);
    chk("t5_len0_detects", det_seen - d0, 3);
    pulse_abort();
    cfg(4'b1000, 3'd7, 1'b0, 8'd0);
    pulse_start();
    d0 = det_seen;
    send_bits(32'b11000, 5);
    chk("t5_len7_detects", det_seen - d0, 1);

    // Randomized runs, including stray start/abort/cfg while running.
    for (int r = 0; r < 8; r++) begin
      pulse_abort();
      cfg(PAT_W'($urandom), LEN_W'($urandom_range(0, 7)), 1'($urandom), CNT_W'($urandom_range(0, 4)));
      pulse_start();
      for (int c = 0; c < 50; c++) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din = 1'($urandom);
        abort = ($urandom_range(0, 59) == 0);
        start = ($urandom_range(0, 29) == 0);
        cfg_valid = ($urandom_range(0, 19) == 0);
        cfg_pattern = PAT_W'($urandom);
        cfg_len = LEN_W'($urandom_range(0, 7));
        cfg_overlap = 1'($urandom);
        cfg_limit = CNT_W'($urandom_range(0, 4));
        tick();
      end
      din_valid = 1'b0; din = 1'b0; abort = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    end

    // Async reset mid-run restores the default configuration.
    pulse_abort();
    cfg(4'b0110, 3'd3, 1'b1, 8'd5);
    pulse_start();
    send_bits(32'b10, 2);
    do_reset();
    pulse_start();
    d0 = det_seen;
    send_bits(32'b1000, 4);
    chk("t7_default_after_reset", det_seen - d0, 1);

`ifdef SEQ_MATCH_CTRL_TIMEOUT_EN
    pulse_abort();
    cfg_timeout = 8'd5;
    cfg(4'b1000, 3'd4, 1'b0, 8'd0);
    cfg_timeout = 8'd0;
    pulse_start();
    send_bits(32'b11111, 5);
    chk("t8_to_done", done, 1);
    chk("t8_to_flag", timeout, 1);
    pulse_start();
    chk("t8_to_cleared", timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
